// File: rtl/fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fpu_issue_ctrl
// Brief   : In-order FPU issue controller with a register scoreboard, an
//           in-flight ID vector and a fixed-latency retirement pipeline.
// Revision: 1.0
// ============================================================================
module fpu_issue_ctrl #(
    parameter int NUM_REGS        = 32,
    parameter int PIPELINE_STAGES = 4,
    parameter int X_ID_WIDTH      = 4
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  i_issue_valid,
    output logic                  o_issue_ready,
    input  logic [31:0]           i_issue_instr,
    input  logic [X_ID_WIDTH-1:0] i_issue_id,
    input  logic [4:0]            i_issue_rs1,
    input  logic [4:0]            i_issue_rs2,
    input  logic [4:0]            i_issue_rs3,
    input  logic [2:0]            i_issue_rs_mask,
    input  logic [4:0]            i_issue_rd,
    input  logic                  i_issue_rd_we,
    input  logic                  i_flush,
    input  logic                  i_drain,
    output logic                  o_fpu_enable,
    output logic                  o_fpu_valid,
    output logic [31:0]           o_fpu_instruction,
    output logic [X_ID_WIDTH-1:0] o_fpu_id,
    output logic                  o_wb_valid,
    output logic [X_ID_WIDTH-1:0] o_wb_id,
    output logic [4:0]            o_wb_rd,
    output logic                  o_wb_we,
    output logic                  o_busy,
    output logic                  o_idle
);

    localparam int c_LAST    = PIPELINE_STAGES - 1;
    localparam int c_NUM_IDS = 1 << X_ID_WIDTH;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_FLUSH = 2'd3;

    logic [1:0]                 r_state;
    logic [1:0]                 w_state_nxt;
    logic                       r_fpu_en;
    logic [PIPELINE_STAGES-1:0] r_pv;
    logic [PIPELINE_STAGES-1:0] r_pwe;
    logic [X_ID_WIDTH-1:0]      r_pid [PIPELINE_STAGES];
    logic [4:0]                 r_prd [PIPELINE_STAGES];
    logic [NUM_REGS-1:0]        r_sb;
    logic [NUM_REGS-1:0]        w_sb_nxt;
    logic [c_NUM_IDS-1:0]       r_idv;
    logic [c_NUM_IDS-1:0]       w_idv_nxt;
    logic                       w_hazard;
    logic                       w_ready;
    logic                       w_xfer;
    logic                       w_retire;
    logic                       w_inflight_nxt;

    // Hazards look only at registered state, so a retirement unblocks next cycle.
    always_comb begin
        w_hazard = r_idv[i_issue_id];
        for (int i = 0; i < NUM_REGS; i++) begin
            if (r_sb[i]) begin
                if (i_issue_rs_mask[0] && i_issue_rs1 == 5'(i)) w_hazard = 1'b1;
                if (i_issue_rs_mask[1] && i_issue_rs2 == 5'(i)) w_hazard = 1'b1;
                if (i_issue_rs_mask[2] && i_issue_rs3 == 5'(i)) w_hazard = 1'b1;
                if (i_issue_rd_we && i_issue_rd == 5'(i))       w_hazard = 1'b1;
            end
        end
    end

    // r_fpu_en doubles as a reset qualifier so nothing is accepted in reset.
    assign w_ready  = r_fpu_en && (r_state == c_ST_IDLE || r_state == c_ST_RUN)
                      && !i_drain && !i_flush && !w_hazard;
    assign w_xfer   = i_issue_valid && w_ready;
    assign w_retire = r_pv[c_LAST];

    assign o_issue_ready     = w_ready;
    assign o_fpu_enable      = r_fpu_en;
    assign o_fpu_valid       = w_xfer;
    assign o_fpu_instruction = w_xfer ? i_issue_instr : 32'h0;
    assign o_fpu_id          = w_xfer ? i_issue_id : '0;
    assign o_wb_valid        = r_pv[c_LAST];
    assign o_wb_id           = r_pid[c_LAST];
    assign o_wb_rd           = r_prd[c_LAST];
    assign o_wb_we           = r_pwe[c_LAST];
    assign o_busy            = |r_pv;
    assign o_idle            = (r_state == c_ST_IDLE);

    always_comb begin
        w_sb_nxt  = r_sb;
        w_idv_nxt = r_idv;
        if (w_retire) begin
            w_idv_nxt[r_pid[c_LAST]] = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_pwe[c_LAST] && r_prd[c_LAST] == 5'(i)) w_sb_nxt[i] = 1'b0;
            end
        end
        if (w_xfer) begin
            w_idv_nxt[i_issue_id] = 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (i_issue_rd_we && i_issue_rd == 5'(i)) w_sb_nxt[i] = 1'b1;
            end
        end
        if (i_flush) begin
            w_sb_nxt  = '0;
            w_idv_nxt = '0;
        end
    end

    // Operations still in flight after this edge: all but the retiring stage.
    always_comb begin
        w_inflight_nxt = w_xfer;
        for (int s = 0; s < c_LAST; s++) begin
            if (r_pv[s]) w_inflight_nxt = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (i_drain)     w_state_nxt = c_ST_DRAIN;
                else if (w_xfer) w_state_nxt = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (i_drain)              w_state_nxt = c_ST_DRAIN;
                else if (!w_inflight_nxt) w_state_nxt = c_ST_IDLE;
            end
            c_ST_DRAIN: begin
                if (!i_drain && !o_busy) w_state_nxt = c_ST_IDLE;
            end
            c_ST_FLUSH: w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
        if (i_flush) w_state_nxt = c_ST_FLUSH;
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_fpu_en <= 1'b0;
            r_pv     <= '0;
            r_pwe    <= '0;
            r_sb     <= '0;
            r_idv    <= '0;
            for (int s = 0; s < PIPELINE_STAGES; s++) begin
                r_pid[s] <= '0;
                r_prd[s] <= '0;
            end
        end else begin
            r_state  <= w_state_nxt;
            r_fpu_en <= 1'b1;
            r_sb     <= w_sb_nxt;
            r_idv    <= w_idv_nxt;
            r_pv[0]  <= w_xfer;
            r_pwe[0] <= i_issue_rd_we;
            r_pid[0] <= i_issue_id;
            r_prd[0] <= i_issue_rd;
            for (int s = 1; s < PIPELINE_STAGES; s++) begin
                r_pv[s]  <= r_pv[s-1] && !i_flush;
                r_pwe[s] <= r_pwe[s-1];
                r_pid[s] <= r_pid[s-1];
                r_prd[s] <= r_prd[s-1];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_issue_ctrl
// Brief   : Directed, self-checking bench for fpu_issue_ctrl with a
//           retirement scoreboard queue.
// Revision: 1.0
// ============================================================================
module tb_fpu_issue_ctrl;

    localparam int P = 4;

    logic        ck;
    logic        rst_n;
    logic        i_issue_valid;
    logic        o_issue_ready;
    logic [31:0] i_issue_instr;
    logic [3:0]  i_issue_id;
    logic [4:0]  i_issue_rs1;
    logic [4:0]  i_issue_rs2;
    logic [4:0]  i_issue_rs3;
    logic [2:0]  i_issue_rs_mask;
    logic [4:0]  i_issue_rd;
    logic        i_issue_rd_we;
    logic        i_flush;
    logic        i_drain;
    logic        o_fpu_enable;
    logic        o_fpu_valid;
    logic [31:0] o_fpu_instruction;
    logic [3:0]  o_fpu_id;
    logic        o_wb_valid;
    logic [3:0]  o_wb_id;
    logic [4:0]  o_wb_rd;
    logic        o_wb_we;
    logic        o_busy;
    logic        o_idle;

    fpu_issue_ctrl #(
        .NUM_REGS        (32),
        .PIPELINE_STAGES (P),
        .X_ID_WIDTH      (4)
    ) u_dut (
        .ck                (ck),
        .rst_n             (rst_n),
        .i_issue_valid     (i_issue_valid),
        .o_issue_ready     (o_issue_ready),
        .i_issue_instr     (i_issue_instr),
        .i_issue_id        (i_issue_id),
        .i_issue_rs1       (i_issue_rs1),
        .i_issue_rs2       (i_issue_rs2),
        .i_issue_rs3       (i_issue_rs3),
        .i_issue_rs_mask   (i_issue_rs_mask),
        .i_issue_rd        (i_issue_rd),
        .i_issue_rd_we     (i_issue_rd_we),
        .i_flush           (i_flush),
        .i_drain           (i_drain),
        .o_fpu_enable      (o_fpu_enable),
        .o_fpu_valid       (o_fpu_valid),
        .o_fpu_instruction (o_fpu_instruction),
        .o_fpu_id          (o_fpu_id),
        .o_wb_valid        (o_wb_valid),
        .o_wb_id           (o_wb_id),
        .o_wb_rd           (o_wb_rd),
        .o_wb_we           (o_wb_we),
        .o_busy            (o_busy),
        .o_idle            (o_idle)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Mid-cycle: every cycle the write-back port must match the queue head.
    task automatic tick();
        logic exp_v;
        exp_t e;
        @(negedge ck);
        exp_v = (q.size() > 0) && (q[0].cyc == 32'(cyc));
        chk($sformatf("wb_valid@%0d", cyc), 64'(o_wb_valid), 64'(exp_v));
        if (exp_v) begin
            e = q.pop_front();
            if (o_wb_valid)
                chk($sformatf("wb_fields@%0d", cyc), 64'({o_wb_id, o_wb_rd, o_wb_we}),
                    64'({e.id, e.rd, e.we}));
        end
        @(posedge ck);
        #1;
        cyc++;
    endtask

    task automatic drive(input string tag, input int id, input int rd, input int we,
                         input int rs1, input int rs2, input int rs3, input int mask,
                         input int exp_rdy);
        logic [31:0] instr;
        exp_t        e;
        instr           = $urandom() | 32'h1;
        i_issue_valid   = 1'b1;
        i_issue_instr   = instr;
        i_issue_id      = 4'(id);
        i_issue_rd      = 5'(rd);
        i_issue_rd_we   = 1'(we);
        i_issue_rs1     = 5'(rs1);
        i_issue_rs2     = 5'(rs2);
        i_issue_rs3     = 5'(rs3);
        i_issue_rs_mask = 3'(mask);
        #1;
        chk({tag, "_ready"}, 64'(o_issue_ready), 64'(exp_rdy));
        chk({tag, "_fpu_valid"}, 64'(o_fpu_valid), 64'(exp_rdy));
        chk({tag, "_fpu_instr"}, 64'(o_fpu_instruction), (exp_rdy != 0) ? 64'(instr) : 64'h0);
        chk({tag, "_fpu_id"}, 64'(o_fpu_id), (exp_rdy != 0) ? 64'(id) : 64'h0);
        if (exp_rdy != 0) begin
            e.id  = 4'(id);
            e.rd  = 5'(rd);
            e.we  = 1'(we);
            e.cyc = 32'(cyc + P);
            q.push_back(e);
        end
        tick();
        i_issue_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 20 && !o_idle; k++) tick();
        chk(tag, 64'(o_idle), 64'h1);
    endtask

    initial begin
        rst_n           = 1'b1;
        i_issue_valid   = 1'b1;
        i_issue_instr   = 32'hDEAD_BEEF;
        i_issue_id      = 4'd1;
        i_issue_rs1     = 5'd0;
        i_issue_rs2     = 5'd0;
        i_issue_rs3     = 5'd0;
        i_issue_rs_mask = 3'd0;
        i_issue_rd      = 5'd3;
        i_issue_rd_we   = 1'b1;
        i_flush         = 1'b0;
        i_drain         = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(o_issue_ready), 64'h0);
        chk("rst_fpu", 64'({o_fpu_enable, o_fpu_valid, o_fpu_instruction, o_fpu_id}), 64'h0);
        chk("rst_wb", 64'({o_wb_valid, o_wb_id, o_wb_rd, o_wb_we}), 64'h0);
        chk("rst_busy", 64'(o_busy), 64'h0);
        chk("rst_idle", 64'(o_idle), 64'h1);
        #10;
        i_issue_valid = 1'b0;
        rst_n         = 1'b1;
        chk("rel_en_before_edge", 64'(o_fpu_enable), 64'h0);
        @(posedge ck);
        #1;
        chk("rel_en_after_edge", 64'(o_fpu_enable), 64'h1);

        // single op
        drive("single", 1, 3, 1, 0, 0, 0, 0, 1);
        repeat (3) tick();
        chk("single_wb", 64'({o_wb_valid, o_wb_id, o_wb_rd}), 64'({1'b1, 4'd1, 5'd3}));
        tick();
        chk("single_idle", 64'({o_idle, o_busy}), 64'({1'b1, 1'b0}));

        // RAW on f5
        drive("rawA", 2, 5, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) drive("rawB_stall", 3, 6, 1, 5, 0, 0, 1, 0);
        drive("rawB_go", 3, 6, 1, 5, 0, 0, 1, 1);
        wait_idle("raw_idle");

        // back-to-back independent ops
        for (int i = 0; i < 8; i++) begin
            drive("b2b", i, 8 + i, 1, 0, 0, 0, 0, 1);
            chk("b2b_busy", 64'(o_busy), 64'h1);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("b2b_tail_busy", 64'(o_busy), 64'h1);
        end
        tick();
        chk("b2b_done", 64'({o_idle, o_busy}), 64'({1'b1, 1'b0}));

        // duplicate ID, WAW, rs2/rs3 masking, no bypass
        drive("dupX", 2, 10, 1, 0, 0, 0, 0, 1);
        for (int k = 0; k < 4; k++) drive("dupY_stall", 2, 11, 1, 0, 0, 0, 0, 0);
        drive("dupY_go", 2, 11, 1, 0, 0, 0, 0, 1);
        drive("waw_stall", 5, 11, 1, 0, 0, 0, 0, 0);
        drive("we0_go", 5, 11, 0, 0, 0, 11, 0, 1);
        drive("rs3_stall", 7, 12, 1, 0, 0, 11, 4, 0);
        drive("rs2_nobypass", 7, 12, 1, 0, 11, 0, 2, 0);
        drive("rs2_go", 7, 12, 1, 0, 11, 0, 2, 1);
        wait_idle("dup_idle");

        // flush with the oldest op in the last stage
        drive("fl_op1", 1, 1, 1, 0, 0, 0, 0, 1);
        drive("fl_op2", 2, 2, 1, 0, 0, 0, 0, 1);
        drive("fl_op3", 3, 3, 1, 0, 0, 0, 0, 1);
        tick();
        i_flush = 1'b1;
        drive("fl_cycle", 4, 4, 1, 0, 0, 0, 0, 0);
        i_flush = 1'b0;
        q.delete();
        chk("fl_busy", 64'(o_busy), 64'h0);
        chk("fl_state", 64'(o_idle), 64'h0);
        drive("fl_state_stall", 2, 9, 1, 2, 3, 0, 3, 0);
        chk("fl_idle", 64'(o_idle), 64'h1);
        drive("fl_sb_clear", 2, 1, 1, 2, 3, 0, 3, 1);
        wait_idle("fl_end_idle");

        // drain
        drive("dr_op1", 8, 20, 1, 0, 0, 0, 0, 1);
        drive("dr_op2", 9, 21, 1, 0, 0, 0, 0, 1);
        i_drain = 1'b1;
        drive("dr_stall", 10, 22, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            chk("dr_not_idle", 64'(o_idle), 64'h0);
            tick();
        end
        chk("dr_empty", 64'({o_busy, o_idle}), 64'h0);
        drive("dr_hold", 10, 22, 1, 0, 0, 0, 0, 0);
        i_drain = 1'b0;
        drive("dr_exit_stall", 10, 22, 1, 0, 0, 0, 0, 0);
        chk("dr_idle", 64'(o_idle), 64'h1);
        drive("dr_after", 10, 22, 1, 0, 0, 0, 0, 1);
        wait_idle("dr_end_idle");

        // reset mid-stream
        drive("rs_op1", 11, 23, 1, 0, 0, 0, 0, 1);
        drive("rs_op2", 12, 24, 1, 0, 0, 0, 0, 1);
        #2;
        rst_n         = 1'b0;
        i_issue_valid = 1'b1;
        i_issue_id    = 4'd13;
        i_issue_rd    = 5'd25;
        #1;
        q.delete();
        chk("mid_rst_ready", 64'(o_issue_ready), 64'h0);
        chk("mid_rst_fpu", 64'({o_fpu_enable, o_fpu_valid, o_fpu_instruction, o_fpu_id}), 64'h0);
        chk("mid_rst_wb", 64'({o_wb_valid, o_wb_id, o_wb_rd, o_wb_we}), 64'h0);
        chk("mid_rst_state", 64'({o_busy, o_idle}), 64'({1'b0, 1'b1}));
        i_issue_valid = 1'b0;
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        chk("mid_rel_en_before", 64'(o_fpu_enable), 64'h0);
        tick();
        chk("mid_rel_en_after", 64'(o_fpu_enable), 64'h1);
        repeat (5) tick();
        chk("mid_rel_quiet", 64'({o_busy, o_idle}), 64'({1'b0, 1'b1}));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
